// File: rtl/scan_mux_pkg.sv
// Shared types and constants for the scan_mux registered channel multiplexer.
package scan_mux_pkg;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    SCAN   = 2'd1,
    BLANK  = 2'd2
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

endpackage

// File: rtl/scan_mux_if.sv
// Channel bus, control and presentation signals of scan_mux, bundled for port connection.
interface scan_mux_if #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned CHANNELS = 9
);
  localparam int unsigned SEL_W = $clog2(CHANNELS);

  logic [WIDTH*CHANNELS-1:0] in_bus;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic                      hold;
  logic [WIDTH-1:0]          out;
  logic [SEL_W-1:0]          out_ch;
  logic [CHANNELS-1:0]       ch_en;
  logic                      out_valid;
  logic                      wrap;

  // master drives data/control, slave (the mux) drives the presentation outputs
  modport master (
    output in_bus, mode, sel, hold,
    input  out, out_ch, ch_en, out_valid, wrap
  );

  modport slave (
    input  in_bus, mode, sel, hold,
    output out, out_ch, ch_en, out_valid, wrap
  );

endinterface

// File: rtl/scan_mux_scan_timer.sv
// Dwell counter for auto scan: clear, hold (freeze) and terminal-count at DWELL-1.
module scan_timer #(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_hold,
  output logic o_tc
);

  localparam int unsigned          CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]     LAST  = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (!i_hold) begin
      r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == LAST);

endmodule

// File: rtl/scan_mux.sv
// N-channel registered mux with manual select and round-robin auto scan.
// Define SCAN_MUX_BLANK_EN to insert one blanked cycle before each auto-scan channel.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned CHANNELS = 9,
  parameter int unsigned DWELL    = 4
) (
  input  logic       clk,
  input  logic       rst,
  scan_mux_if.slave  bus
);

  localparam int unsigned         SEL_W   = $clog2(CHANNELS);
  localparam logic [SEL_W-1:0]    LAST_CH = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W:0]      NUM_CH  = (SEL_W + 1)'(CHANNELS);
  localparam logic [CHANNELS-1:0] ONE     = CHANNELS'(1);

  state_e              r_state;
  logic [WIDTH-1:0]    r_out;
  logic [SEL_W-1:0]    r_out_ch;
  logic [CHANNELS-1:0] r_ch_en;
  logic                r_valid;
  logic                r_wrap;

  logic                w_tc;
  logic                w_tmr_clr;
  logic                w_sel_ok;
  logic [SEL_W-1:0]    w_next_ch;
  logic [WIDTH-1:0]    w_sel_data;
  logic [WIDTH-1:0]    w_cur_data;
  logic [WIDTH-1:0]    w_next_data;

  assign w_sel_ok  = ({1'b0, bus.sel} < NUM_CH);
  assign w_next_ch = (r_out_ch == LAST_CH) ? '0 : r_out_ch + 1'b1;
  assign w_tmr_clr = (r_state != SCAN) || (bus.mode == MODE_MANUAL);

  // Loop lookup keeps unreachable select codes from indexing past in_bus.
  always_comb begin
    w_sel_data  = '0;
    w_cur_data  = '0;
    w_next_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (SEL_W'(k) == bus.sel)   w_sel_data  = bus.in_bus[k*WIDTH +: WIDTH];
      if (SEL_W'(k) == r_out_ch)  w_cur_data  = bus.in_bus[k*WIDTH +: WIDTH];
      if (SEL_W'(k) == w_next_ch) w_next_data = bus.in_bus[k*WIDTH +: WIDTH];
    end
  end

  scan_timer #(
    .DWELL (DWELL)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_tmr_clr),
    .i_hold (bus.hold),
    .o_tc   (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= MANUAL;
      r_out    <= '0;
      r_out_ch <= '0;
      r_ch_en  <= '0;
      r_valid  <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      // Manual mode wins over any pending scan advance or blank cycle.
      if (bus.mode == MODE_MANUAL) begin
        r_state <= MANUAL;
        if (w_sel_ok) begin
          r_out    <= w_sel_data;
          r_out_ch <= bus.sel;
          r_ch_en  <= ONE << bus.sel;
          r_valid  <= 1'b1;
        end else begin
          r_ch_en  <= '0;
          r_valid  <= 1'b0;
        end
      end else begin
        case (r_state)
          SCAN: begin
            if (w_tc && !bus.hold) begin
              r_out_ch <= w_next_ch;
`ifdef SCAN_MUX_BLANK_EN
              r_state  <= BLANK;
              r_out    <= '0;
              r_ch_en  <= '0;
              r_valid  <= 1'b0;
`else
              r_out    <= w_next_data;
              r_ch_en  <= ONE << w_next_ch;
              r_valid  <= 1'b1;
              r_wrap   <= (w_next_ch == '0);
`endif
            end else begin
              r_out    <= w_cur_data;
              r_ch_en  <= ONE << r_out_ch;
              r_valid  <= 1'b1;
            end
          end
`ifdef SCAN_MUX_BLANK_EN
          BLANK: begin
            r_state <= SCAN;
            r_out   <= w_cur_data;
            r_ch_en <= ONE << r_out_ch;
            r_valid <= 1'b1;
            r_wrap  <= (r_out_ch == '0);
          end
`endif
          default: begin
            // Entering auto scan from MANUAL starts at the channel already shown.
            r_state <= SCAN;
            r_out   <= w_cur_data;
            r_ch_en <= ONE << r_out_ch;
            r_valid <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.out       = r_out;
  assign bus.out_ch    = r_out_ch;
  assign bus.ch_en     = r_ch_en;
  assign bus.out_valid = r_valid;
  assign bus.wrap      = r_wrap;

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux (WIDTH=4, CHANNELS=9, DWELL=3, channel k carries k+1).
module tb_scan_mux;

  localparam int WIDTH    = 4;
  localparam int CHANNELS = 9;
  localparam int DWELL    = 3;
`ifdef SCAN_MUX_BLANK_EN
  localparam int PERIOD   = DWELL + 1;
`else
  localparam int PERIOD   = DWELL;
`endif

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  scan_mux_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) u_if ();

  scan_mux #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .DWELL    (DWELL)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sel;
    logic [3:0] exp_out;
    logic [3:0] exp_ch;
    logic [8:0] exp_en;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [3:0] v);
    u_if.in_bus[k*WIDTH +: WIDTH] = v;
  endtask

  initial begin
    int          ch;
    logic        blank;
    logic [8:0]  en;
    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{4'd0,  4'h1, 4'd0, 9'h001, 1'b1};
    vecs[1] = '{4'd8,  4'h9, 4'd8, 9'h100, 1'b1};
    vecs[2] = '{4'd12, 4'h9, 4'd8, 9'h000, 1'b0};
    vecs[3] = '{4'd3,  4'h4, 4'd3, 9'h008, 1'b1};
    vecs[4] = '{4'd9,  4'h4, 4'd3, 9'h000, 1'b0};
    vecs[5] = '{4'd15, 4'h4, 4'd3, 9'h000, 1'b0};
    vecs[6] = '{4'd5,  4'h6, 4'd5, 9'h020, 1'b1};

    rst         = 1'b1;
    u_if.mode   = 1'b0;
    u_if.sel    = '0;
    u_if.hold   = 1'b0;
    for (int k = 0; k < CHANNELS; k++) set_ch(k, 4'(k + 1));

    #3;
    chk("rst_out",   32'(u_if.out),       0);
    chk("rst_ch",    32'(u_if.out_ch),    0);
    chk("rst_en",    32'(u_if.ch_en),     0);
    chk("rst_valid", 32'(u_if.out_valid), 0);
    chk("rst_wrap",  32'(u_if.wrap),      0);

    step();
    rst = 1'b0;

    // Manual select table, including out-of-range selects that must hold out/out_ch.
    for (int i = 0; i < 7; i++) begin
      u_if.sel = vecs[i].sel;
      step();
      chk("man_out",   32'(u_if.out),       32'(vecs[i].exp_out));
      chk("man_ch",    32'(u_if.out_ch),    32'(vecs[i].exp_ch));
      chk("man_en",    32'(u_if.ch_en),     32'(vecs[i].exp_en));
      chk("man_valid", 32'(u_if.out_valid), 32'(vecs[i].exp_valid));
      chk("man_wrap",  32'(u_if.wrap),      0);
    end

    // Full auto frame from channel 0.
    u_if.sel = 4'd0;
    step();
    u_if.mode = 1'b1;
    step();
    chk("scan_entry_ch", 32'(u_if.out_ch), 0);
    chk("scan_entry_valid", 32'(u_if.out_valid), 1);
    for (int i = 1; i <= CHANNELS * PERIOD + 1; i++) begin
      step();
      blank = ((i % PERIOD) == DWELL);
      ch    = ((i / PERIOD) + (blank ? 1 : 0)) % CHANNELS;
      en    = blank ? 9'h000 : (9'h001 << ch);
      chk("scan_ch",    32'(u_if.out_ch),    32'(ch));
      chk("scan_valid", 32'(u_if.out_valid), blank ? 0 : 1);
      chk("scan_out",   32'(u_if.out),       blank ? 0 : 32'(ch + 1));
      chk("scan_en",    32'(u_if.ch_en),     32'(en));
      chk("scan_wrap",  32'(u_if.wrap),      (i == CHANNELS * PERIOD) ? 1 : 0);
    end

    // Hold at channel 4 with its input changing underneath.
    u_if.mode = 1'b0;
    u_if.sel  = 4'd4;
    step();
    u_if.mode = 1'b1;
    step();
    step();
    u_if.hold = 1'b1;
    set_ch(4, 4'hA);
    step();
    chk("hold_out", 32'(u_if.out), 32'hA);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("hold_ch", 32'(u_if.out_ch), 4);
    end
    u_if.hold = 1'b0;
    step();
    chk("release_ch_wait", 32'(u_if.out_ch), 4);
    step();
    chk("release_ch_adv", 32'(u_if.out_ch), 5);
    set_ch(4, 4'h5);

    // Auto at channel 3, drop to manual with sel=7, then resume scanning from 7.
    u_if.mode = 1'b0;
    u_if.sel  = 4'd3;
    step();
    u_if.mode = 1'b1;
    step();
    step();
    chk("ms_pre_ch", 32'(u_if.out_ch), 3);
    u_if.mode = 1'b0;
    u_if.sel  = 4'd7;
    step();
    chk("ms_ch",    32'(u_if.out_ch),    7);
    chk("ms_out",   32'(u_if.out),       32'h8);
    chk("ms_en",    32'(u_if.ch_en),     32'h080);
    chk("ms_valid", 32'(u_if.out_valid), 1);
    u_if.mode = 1'b1;
    step();
    step();
    step();
    chk("ms_resume_hold", 32'(u_if.out_ch), 7);
    step();
    chk("ms_resume_adv", 32'(u_if.out_ch), 8);

    // Asynchronous reset mid-scan at channel 5.
    u_if.mode = 1'b0;
    u_if.sel  = 4'd5;
    step();
    u_if.mode = 1'b1;
    step();
    step();
    chk("arst_pre_ch", 32'(u_if.out_ch), 5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out",   32'(u_if.out),       0);
    chk("arst_ch",    32'(u_if.out_ch),    0);
    chk("arst_en",    32'(u_if.ch_en),     0);
    chk("arst_valid", 32'(u_if.out_valid), 0);
    chk("arst_wrap",  32'(u_if.wrap),      0);
    step();
    u_if.mode = 1'b0;
    u_if.sel  = 4'd2;
    rst       = 1'b0;
    step();
    chk("post_rst_ch",  32'(u_if.out_ch), 2);
    chk("post_rst_out", 32'(u_if.out),    32'h3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_mux.md
# scan_mux

Parametrised N-channel registered multiplexer with an automatic round-robin scan mode, for time-multiplexed outputs such as digit/row strobing of displays. Supersedes fixed-width combinational muxes: channel count and width are parameters, select width derives from the channel count so every channel is reachable, and the output is registered with a one-hot channel enable and a valid flag. Sits between the data sources and the display/output drivers.

## Interface
- WIDTH, 1, bits per channel
- CHANNELS, 9, number of input channels (≥2)
- DWELL, 4, cycles each channel is presented in auto mode (≥1)
- SEL_W (localparam), $clog2(CHANNELS), select/channel-index width

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_bus  in  WIDTH*CHANNELS  channel k at [k*WIDTH +: WIDTH]
- mode  in  1  0 = manual (sel), 1 = auto scan
- sel  in  SEL_W  manual channel select
- hold  in  1  auto mode: freeze dwell counter and channel
- out  out  WIDTH  registered selected data
- out_ch  out  SEL_W  index of channel currently on out
- ch_en  out  CHANNELS  one-hot of out_ch; all-zero when not valid
- out_valid  out  1  out/out_ch are a legal channel presentation
- wrap  out  1  one-cycle pulse when auto scan returns to channel 0

## Operation
- States: MANUAL, SCAN, BLANK (BLANK only with macro). Reset → MANUAL; all outputs 0, dwell count 0.
- MANUAL, sel < CHANNELS: each edge out←in_bus[sel], out_ch←sel, ch_en←1<<sel, out_valid←1.
- MANUAL, sel ≥ CHANNELS: out_valid←0, ch_en←0; out and out_ch hold.
- mode 0→1: go to SCAN from current out_ch, dwell count 0. mode 1→0: go to MANUAL, count 0, sel taken same edge.
- SCAN: out←in_bus[out_ch] every edge (data tracks live input), out_valid=1, ch_en one-hot. Count increments; at count=DWELL-1 and hold=0: count←0, out_ch←next (CHANNELS-1 wraps to 0, not 2^SEL_W-1), out←in_bus[next].
- hold=1 in SCAN: count and out_ch frozen; out keeps tracking in_bus[out_ch]. Release resumes from frozen count.
- wrap=1 exactly on the edge out_ch becomes 0 via scan advance; never in MANUAL.

## Timing
- Latency 1 cycle: input/sel change at edge n visible on out at edge n+1.
- Auto channel period DWELL cycles; full frame CHANNELS*DWELL cycles.
- Async reset clears outputs immediately, independent of clk; first load on first edge after rst deasserts.
- mode and hold sampled on the same edge; mode change takes priority over advance.

## Configuration
- SCAN_MUX_BLANK_EN defined: each auto advance passes through one BLANK cycle (out=0, ch_en=0, out_valid=0, out_ch already shows next channel); period DWELL+1, wrap asserted on the edge leaving BLANK into channel 0. Mode change in BLANK goes directly to MANUAL. Manual mode unaffected.
- Undefined: no BLANK state; advance is direct as above.

## Structure
- Package scan_mux_pkg: state enum (MANUAL, SCAN, BLANK), mode constants MODE_MANUAL/MODE_AUTO.
- One sub-module: scan_timer (dwell counter with clear, hold, terminal-count output).

## Test plan
Common: WIDTH=4, CHANNELS=9, DWELL=3, channel k input = k+1.
- Manual sel=8 → next edge out=4'h9, out_ch=8, ch_en=9'h100, out_valid=1; then sel=12 → out_valid=0, ch_en=0, out stays 4'h9.
- Auto from ch0 → out_ch steps 0..8 every 3 cycles; wrap high one cycle at edge 27 with out_ch=0; never reaches 9.
- Hold at out_ch=4 for 10 cycles, in4 changed to 4'hA → out_ch stays 4, out=4'hA next edge; release → advances after remaining dwell cycles.
- Auto at ch3, mode→0 with sel=7 → next edge out_ch=7, out=4'h8; mode→1 → scan resumes from 7, advances to 8 after 3 cycles.
- rst asserted mid-scan at out_ch=5 → out, out_ch, ch_en, out_valid, wrap all 0 before next edge; after release state MANUAL.
- SCAN_MUX_BLANK_EN: period 4 cycles, one cycle out=0, ch_en=0, out_valid=0 before each new channel; frame 36 cycles.
